// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, fixed-latency memory between the fetch (I) and
// data (D) ports. D has priority and the port just acked sits out for one cycle.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_rd_i,
  input  logic              dm_wr_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              stall_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_req_s, dm_req_s, done_s;

  // Next-state and registered-output decode; the acked port is masked for one cycle.
  always_comb begin
    if_req_s    = if_req_i & ~if_ack_q;
    dm_req_s    = (dm_rd_i | dm_wr_i) & ~dm_ack_q;
    done_s      = (cnt_q <= 4'd1);
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (dm_req_s) begin
          state_d     = BUSY_D;
          cnt_d       = LAT_LOAD;
          wr_d        = dm_wr_i;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_wr_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
        end else if (if_req_s) begin
          state_d    = BUSY_I;
          cnt_d      = LAT_LOAD;
          wr_d       = 1'b0;
          mem_en_d   = 1'b1;
          mem_addr_d = if_addr_i;
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      BUSY_I: begin
        if (done_s) begin
          state_d    = IDLE;
          cnt_d      = 4'd0;
          if_ack_d   = 1'b1;
          if_rdata_d = mem_rdata_i;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      BUSY_D: begin
        if (done_s) begin
          state_d  = IDLE;
          cnt_d    = 4'd0;
          dm_ack_d = 1'b1;
          if (!wr_q) begin
            dm_rdata_d = mem_rdata_i;
          end else begin
            dm_rdata_d = dm_rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, counter and all registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign stall_o     = (if_req_i & ~if_ack_q) | ((dm_rd_i | dm_wr_i) & ~dm_ack_q);
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed cases plus random concurrent
// fetch/data traffic against a word-array memory model; a second instance runs MEM_LAT=1.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} mtx_t;
  typedef struct {logic we; logic [31:0] rdata;} dtx_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic if_req_i = 1'b0, dm_rd_i = 1'b0, dm_wr_i = 1'b0;
  logic [31:0] if_addr_i = 32'h0, dm_addr_i = 32'h0, dm_wdata_i = 32'h0;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'h0;
  logic if_ack_o, dm_ack_o, stall_o, mem_en_o, mem_we_o;

  logic if_req_1 = 1'b0;
  logic [31:0] if_addr_1 = 32'h0;
  logic [31:0] if_rdata_1, dm_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
  logic if_ack_1, dm_ack_1, stall_1, mem_en_1, mem_we_1;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] env_mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] if_q [$];
  dtx_t        dm_q [$];
  mtx_t        if_mq [$];
  mtx_t        dm_mq [$];
  logic [31:0] ref_if_last = 32'h0, ref_dm_last = 32'h0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .dm_rd_i(dm_rd_i), .dm_wr_i(dm_wr_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o), .stall_o(stall_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_1), .if_addr_i(if_addr_1), .if_rdata_o(if_rdata_1), .if_ack_o(if_ack_1),
    .dm_rd_i(1'b0), .dm_wr_i(1'b0), .dm_addr_i(32'h0), .dm_wdata_i(32'h0),
    .dm_rdata_o(dm_rdata_1), .dm_ack_o(dm_ack_1), .stall_o(stall_1),
    .mem_en_o(mem_en_1), .mem_we_o(mem_we_1), .mem_addr_o(mem_addr_1),
    .mem_wdata_o(mem_wdata_1), .mem_rdata_i(mem_rdata_1)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] hashf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Zero-latency memory for the MEM_LAT=1 instance: data valid in the mem_en cycle.
  assign mem_rdata_1 = mem_en_1 ? hashf(mem_addr_1) : 32'hBAD0_BAD0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic fail(input string n);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", n, cyc);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_if(input logic [31:0] a);
    if_q.push_back(ref_mem[a[9:2]]);
    if_mq.push_back('{a, 1'b0, 32'h0});
  endtask

  task automatic issue_dm(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] wd);
    dtx_t d;
    d.we = wr;
    d.rdata = ref_mem[a[9:2]];
    if (wr) ref_mem[a[9:2]] = wd;
    dm_q.push_back(d);
    dm_mq.push_back('{a, wr, wd});
    dm_addr_i = a;
    dm_wdata_i = wd;
    dm_rd_i = rd;
    dm_wr_i = wr;
  endtask

  task automatic wait_if(output int c);
    c = -1;
    for (int k = 0; k < 64; k++) begin
      step();
      if (if_ack_o) begin c = cyc; break; end
    end
    if (c < 0) fail("if_ack_timeout");
  endtask

  task automatic wait_dm(output int c);
    c = -1;
    for (int k = 0; k < 64; k++) begin
      step();
      if (dm_ack_o) begin c = cyc; break; end
    end
    if (c < 0) fail("dm_ack_timeout");
  endtask

  // Memory environment: returns read data in the cycle MEM_LAT-1 after mem_en, else junk.
  initial begin
    int rd_cnt;
    logic [31:0] rd_addr;
    rd_cnt = 0;
    rd_addr = 32'h0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        rd_cnt = 0;
        mem_rdata_i = 32'h0;
      end else begin
        if (mem_en_o) begin
          rd_cnt = LAT;
          rd_addr = mem_addr_o;
          if (mem_we_o) env_mem[mem_addr_o[9:2]] = mem_wdata_o;
        end
        if (rd_cnt == 1) mem_rdata_i = env_mem[rd_addr[9:2]];
        else mem_rdata_i = $urandom;
        if (rd_cnt != 0) rd_cnt--;
      end
    end
  end

  // Monitor: pairs each mem_en with the next ack and checks it against the port's queues.
  initial begin
    mtx_t pend, m;
    dtx_t d;
    logic [31:0] e;
    logic pend_v, prev_if, prev_dm;
    int pend_cyc;
    pend_v = 1'b0; prev_if = 1'b0; prev_dm = 1'b0; pend_cyc = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if_q.delete(); dm_q.delete(); if_mq.delete(); dm_mq.delete();
        pend_v = 1'b0; prev_if = 1'b0; prev_dm = 1'b0;
        ref_if_last = 32'h0; ref_dm_last = 32'h0;
      end else begin
        chk("stall", 32'(stall_o), 32'((if_req_i & ~if_ack_o) | ((dm_rd_i | dm_wr_i) & ~dm_ack_o)));
        chk("ack_overlap", 32'(if_ack_o & dm_ack_o), 32'h0);
        chk("if_ack_width", 32'(if_ack_o & prev_if), 32'h0);
        chk("dm_ack_width", 32'(dm_ack_o & prev_dm), 32'h0);
        prev_if = if_ack_o;
        prev_dm = dm_ack_o;
        if (if_ack_o) begin
          if (if_q.size() == 0 || if_mq.size() == 0 || !pend_v) fail("if_ack_unexpected");
          else begin
            e = if_q.pop_front();
            m = if_mq.pop_front();
            chk("if_rdata", if_rdata_o, e);
            chk("if_mem_addr", pend.addr, m.addr);
            chk("if_mem_we", 32'(pend.we), 32'(m.we));
            chk("if_mem_wdata", pend.wdata, m.wdata);
            chk("if_latency", 32'(cyc - pend_cyc), 32'(LAT));
            ref_if_last = e;
          end
          pend_v = 1'b0;
        end else chk("if_rdata_hold", if_rdata_o, ref_if_last);
        if (dm_ack_o) begin
          if (dm_q.size() == 0 || dm_mq.size() == 0 || !pend_v) fail("dm_ack_unexpected");
          else begin
            d = dm_q.pop_front();
            m = dm_mq.pop_front();
            if (d.we) chk("dm_rdata_store", dm_rdata_o, ref_dm_last);
            else begin
              chk("dm_rdata", dm_rdata_o, d.rdata);
              ref_dm_last = d.rdata;
            end
            chk("dm_mem_addr", pend.addr, m.addr);
            chk("dm_mem_we", 32'(pend.we), 32'(m.we));
            chk("dm_mem_wdata", pend.wdata, m.wdata);
            chk("dm_latency", 32'(cyc - pend_cyc), 32'(LAT));
          end
          pend_v = 1'b0;
        end else chk("dm_rdata_hold", dm_rdata_o, ref_dm_last);
        if (mem_en_o) begin
          if (pend_v) fail("mem_en_overlap");
          pend = '{mem_addr_o, mem_we_o, mem_wdata_o};
          pend_v = 1'b1;
          pend_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int cd, ci, n, last_ack, last_en;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = hashf(32'(i) << 2);
      ref_mem[i] = hashf(32'(i) << 2);
    end
    env_mem[16] = 32'h8C01_0004; ref_mem[16] = 32'h8C01_0004;
    env_mem[64] = 32'h0000_0055; ref_mem[64] = 32'h0000_0055;

    #1 rst_i = 1'b0;
    #2;
    chk("rst_mem_en", 32'(mem_en_o), 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_if_ack", 32'(if_ack_o), 32'h0);
    chk("rst_dm_ack", 32'(dm_ack_o), 32'h0);
    chk("rst_if_rdata", if_rdata_o, 32'h0);
    chk("rst_dm_rdata", dm_rdata_o, 32'h0);
    chk("rst_stall", 32'(stall_o), 32'h0);
    step();
    rst_i = 1'b1;
    step();

    // Fetch only: mem_en in cycle 1, ack in cycle LAT+1, stall through cycle LAT.
    if_addr_i = 32'h40; if_req_i = 1'b1; push_if(32'h40);
    #1;
    for (int k = 0; k <= LAT + 2; k++) begin
      if (k > 0) step();
      chk("t1_en", 32'(mem_en_o), 32'(k == 1));
      if (k == 1) chk("t1_addr", mem_addr_o, 32'h40);
      chk("t1_ack", 32'(if_ack_o), 32'(k == LAT + 1));
      chk("t1_stall", 32'(stall_o), 32'(k <= LAT));
      if (k == LAT + 1) begin
        chk("t1_rdata", if_rdata_o, 32'h8C01_0004);
        if_req_i = 1'b0;
      end
    end

    // Simultaneous requests: D first, I issued from the D ack cycle.
    if_addr_i = 32'h44; if_req_i = 1'b1; push_if(32'h44);
    issue_dm(32'h100, 1'b1, 1'b0, 32'hA0A0_0001);
    step();
    chk("t2_en_d", 32'(mem_en_o), 32'h1);
    chk("t2_addr_d", mem_addr_o, 32'h100);
    dm_addr_i = 32'h3FC; dm_wdata_i = 32'hFFFF_FFFF;
    wait_dm(cd);
    chk("t2_dm_rdata", dm_rdata_o, 32'h55);
    dm_rd_i = 1'b0;
    wait_if(ci);
    chk("t2_if_after_dm", 32'(ci - cd), 32'(LAT + 1));
    if_req_i = 1'b0;
    step();

    // Store: single enabled cycle with write data, load data register untouched.
    issue_dm(32'h20, 1'b0, 1'b1, 32'hDEAD_BEEF);
    step();
    chk("t3_en", 32'(mem_en_o), 32'h1);
    chk("t3_we", 32'(mem_we_o), 32'h1);
    chk("t3_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    step();
    chk("t3_en_once", 32'(mem_en_o), 32'h0);
    wait_dm(cd);
    chk("t3_dm_rdata_kept", dm_rdata_o, 32'h55);
    dm_wr_i = 1'b0;
    step();

    // Both rd and wr high is a store; read it back afterwards.
    issue_dm(32'h104, 1'b1, 1'b1, 32'h1234_5678);
    step();
    chk("t6_we", 32'(mem_we_o), 32'h1);
    wait_dm(cd);
    chk("t6_dm_rdata_kept", dm_rdata_o, 32'h55);
    dm_rd_i = 1'b0; dm_wr_i = 1'b0;
    step();
    issue_dm(32'h104, 1'b1, 1'b0, 32'h0);
    wait_dm(cd);
    chk("t6_readback", dm_rdata_o, 32'h1234_5678);
    dm_rd_i = 1'b0;
    step();

    // Reset during BUSY_D: outputs clear at once and the access is never acked.
    issue_dm(32'h108, 1'b1, 1'b0, 32'h0);
    step();
    chk("t5_busy_en", 32'(mem_en_o), 32'h1);
    #2 rst_i = 1'b0;
    #1;
    chk("t5_mem_en", 32'(mem_en_o), 32'h0);
    chk("t5_mem_addr", mem_addr_o, 32'h0);
    chk("t5_dm_rdata", dm_rdata_o, 32'h0);
    chk("t5_if_rdata", if_rdata_o, 32'h0);
    dm_rd_i = 1'b0;
    step();
    step();
    rst_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t5_no_dm_ack", 32'(dm_ack_o), 32'h0);
      chk("t5_no_mem_en", 32'(mem_en_o), 32'h0);
    end
    issue_dm(32'h108, 1'b1, 1'b0, 32'h0);
    wait_dm(cd);
    chk("t5_recover", dm_rdata_o, hashf(32'h108));
    dm_rd_i = 1'b0;
    step();

    // MEM_LAT=1 instance: held fetch request, address stepping by 4.
    a = 32'h80; if_addr_1 = a; if_req_1 = 1'b1;
    n = 0; last_ack = -100; last_en = -100;
    for (int k = 0; k < 60 && n < 4; k++) begin
      step();
      if (mem_en_1) begin
        chk("t4_en_addr", mem_addr_1, a);
        if (n > 0) chk("t4_regrant_gap", 32'(cyc - last_ack), 32'h2);
        last_en = cyc;
      end
      chk("t4_stall", 32'(stall_1), 32'(!if_ack_1));
      if (if_ack_1) begin
        chk("t4_ack_lat", 32'(cyc - last_en), 32'h1);
        chk("t4_rdata", if_rdata_1, hashf(a));
        last_ack = cyc; n++; a = a + 32'h4; if_addr_1 = a;
      end
    end
    if_req_1 = 1'b0;
    chk("t4_count", 32'(n), 32'h4);

    // Random concurrent traffic; I and D use disjoint address ranges.
    fork
      begin
        int c;
        logic [31:0] fa;
        for (int t = 0; t < 40; t++) begin
          repeat ($urandom_range(0, 3)) step();
          fa = 32'($urandom_range(0, 63)) << 2;
          if_addr_i = fa; if_req_i = 1'b1; push_if(fa);
          wait_if(c);
          if_req_i = 1'b0; if_addr_i = $urandom;
        end
      end
      begin
        int c, op;
        logic [31:0] da;
        for (int t = 0; t < 40; t++) begin
          repeat ($urandom_range(0, 3)) step();
          op = $urandom_range(0, 2);
          da = 32'h100 + (32'($urandom_range(0, 191)) << 2);
          issue_dm(da, op != 1, op != 0, $urandom);
          wait_dm(c);
          dm_rd_i = 1'b0; dm_wr_i = 1'b0;
        end
      end
    join
    repeat (4) step();
    chk("final_if_queue_empty", 32'(if_q.size()), 32'h0);
    chk("final_dm_queue_empty", 32'(dm_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
